uart_echo_responder: RTL and testbench

UART_ECHO_RESPONDER -- requirements
Module: uart_echo_responder

---
 rtl/uart_echo_responder.sv | 155 +++++++++++++++
 tb/tb_uart_echo_responder.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_echo_responder.sv
// UART echo responder: buffers received bytes in a circular FIFO and replays them
// to a UART transmitter with a two-cycle request and a low-then-high done handshake.
module uart_echo_responder #(
  parameter int unsigned DEPTH      = 8,
  parameter bit          UPPER_CASE = 1'b0
) (
  input  logic                     i_SysClock,
  input  logic                     i_ResetN,
  input  logic [7:0]               i_RxByte,
  input  logic                     i_RxDone,
  output logic                     o_TxValid,
  output logic [7:0]               o_TxByte,
  input  logic                     i_TxDone,
  input  logic                     i_ClrOverflow,
  output logic                     o_Overflow,
  output logic [$clog2(DEPTH):0]   o_Count,
  output logic                     o_Busy
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SEND      = 2'd1,
    WAIT_LOW  = 2'd2,
    WAIT_HIGH = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic            send_cnt_q, send_cnt_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            tx_valid_q, tx_valid_d;
  logic [7:0]      tx_byte_q, tx_byte_d;
  logic            ovf_q, ovf_d;
  logic            busy_q, busy_d;
  logic            rx_prev_q;
  logic [7:0]      mem_q [DEPTH];

  logic            wr_evt;
  logic            pop;
  logic            full;
  logic            wr_en;
  logic            ovf_set;
  logic [7:0]      wr_byte;

  // Write/pop decisions; a pop in the same cycle frees the slot a full-FIFO write needs.
  always_comb begin
    wr_evt  = i_RxDone & ~rx_prev_q;
    pop     = (state_q == IDLE) && (count_q != '0);
    full    = (count_q == CW'(DEPTH));
    wr_en   = wr_evt && (!full || pop);
    ovf_set = wr_evt && full && !pop;
    wr_byte = i_RxByte;
    if (UPPER_CASE && (i_RxByte >= 8'h61) && (i_RxByte <= 8'h7A)) begin
      wr_byte = i_RxByte - 8'h20;
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d    = state_q;
    send_cnt_d = send_cnt_q;
    tx_byte_d  = tx_byte_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;

    case (state_q)
      IDLE: begin
        if (pop) begin
          state_d    = SEND;
          send_cnt_d = 1'b0;
          tx_byte_d  = mem_q[rd_ptr_q];
        end
      end
      SEND: begin
        if (!send_cnt_q) begin
          send_cnt_d = 1'b1;
        end else begin
          state_d = WAIT_LOW;
        end
      end
      WAIT_LOW: begin
        if (!i_TxDone) begin
          state_d = WAIT_HIGH;
        end
      end
      WAIT_HIGH: begin
        if (i_TxDone) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    if (wr_en) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
    end
    case ({wr_en, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    tx_valid_d = (state_d == SEND);
    ovf_d      = ovf_set ? 1'b1 : (i_ClrOverflow ? 1'b0 : ovf_q);
    busy_d     = (state_d != IDLE) || (count_d != '0);
  end

  always_ff @(posedge i_SysClock) begin
    if (!i_ResetN) begin
      state_q    <= IDLE;
      send_cnt_q <= 1'b0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      tx_valid_q <= 1'b0;
      tx_byte_q  <= 8'h00;
      ovf_q      <= 1'b0;
      busy_q     <= 1'b0;
      rx_prev_q  <= 1'b1;
    end else begin
      state_q    <= state_d;
      send_cnt_q <= send_cnt_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      tx_valid_q <= tx_valid_d;
      tx_byte_q  <= tx_byte_d;
      ovf_q      <= ovf_d;
      busy_q     <= busy_d;
      rx_prev_q  <= i_RxDone;
    end
  end

  // Storage needs no reset: the pointers and count define which entries are live.
  always_ff @(posedge i_SysClock) begin
    if (i_ResetN && wr_en) begin
      mem_q[wr_ptr_q] <= wr_byte;
    end
  end

  assign o_TxValid  = tx_valid_q;
  assign o_TxByte   = tx_byte_q;
  assign o_Overflow = ovf_q;
  assign o_Count    = count_q;
  assign o_Busy     = busy_q;

endmodule

// File: tb/tb_uart_echo_responder.sv
// Bench for uart_echo_responder: two instances (plain and upper-case) driven in lockstep
// and compared every cycle against a queue-based transaction model.
module tb_uart_echo_responder;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [7:0]    rx_byte = 8'h00;
  logic          rx_done = 1'b0;
  logic          tx_done = 1'b0;
  logic          clr = 1'b0;

  logic          tv0, tv1, ovf0, ovf1, busy0, busy1;
  logic [7:0]    tb0, tb1;
  logic [CW-1:0] cnt0, cnt1;

  int n_vec = 0;
  int n_err = 0;

  // model state: phase 0 idle, 1/2 request cycles, 3 await done low, 4 await done high
  logic [7:0] mq[$];
  int         m_ph = 0;
  logic [7:0] m_txb = 8'h00;
  bit         m_ovf = 1'b0;
  bit         m_prev = 1'b1;

  int         rises0 = 0, rises1 = 0;
  bit         pv0 = 1'b0, pv1 = 1'b0;
  logic [7:0] echo0[$];
  int         peak0 = 0;

  always #5 clk = ~clk;

  uart_echo_responder #(.DEPTH(DEPTH), .UPPER_CASE(1'b0)) dut0 (
    .i_SysClock(clk), .i_ResetN(rst_n), .i_RxByte(rx_byte), .i_RxDone(rx_done),
    .o_TxValid(tv0), .o_TxByte(tb0), .i_TxDone(tx_done), .i_ClrOverflow(clr),
    .o_Overflow(ovf0), .o_Count(cnt0), .o_Busy(busy0)
  );

  uart_echo_responder #(.DEPTH(DEPTH), .UPPER_CASE(1'b1)) dut1 (
    .i_SysClock(clk), .i_ResetN(rst_n), .i_RxByte(rx_byte), .i_RxDone(rx_done),
    .o_TxValid(tv1), .o_TxByte(tb1), .i_TxDone(tx_done), .i_ClrOverflow(clr),
    .o_Overflow(ovf1), .o_Count(cnt1), .o_Busy(busy1)
  );

  function automatic logic [7:0] upc(input logic [7:0] b);
    return (b >= 8'h61 && b <= 8'h7A) ? b - 8'h20 : b;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_step();
    int pre_cnt;
    bit wr, pop, set;
    if (!rst_n) begin
      mq.delete();
      m_ph = 0; m_txb = 8'h00; m_ovf = 1'b0; m_prev = 1'b1;
    end else begin
      wr      = rx_done && !m_prev;
      m_prev  = rx_done;
      pre_cnt = mq.size();
      pop     = (m_ph == 0) && (pre_cnt != 0);
      set     = 1'b0;
      case (m_ph)
        0: if (pop) begin m_txb = mq.pop_front(); m_ph = 1; end
        1: m_ph = 2;
        2: m_ph = 3;
        3: if (!tx_done) m_ph = 4;
        default: if (tx_done) m_ph = 0;
      endcase
      if (wr) begin
        if (pre_cnt < DEPTH || pop) mq.push_back(rx_byte);
        else set = 1'b1;
      end
      m_ovf = set ? 1'b1 : (clr ? 1'b0 : m_ovf);
    end
  endtask

  task automatic check_all();
    bit ev;
    bit eb;
    ev = (m_ph == 1) || (m_ph == 2);
    eb = (m_ph != 0) || (mq.size() != 0);
    chk("txvalid0", 32'(tv0), 32'(ev));
    chk("txbyte0", 32'(tb0), 32'(m_txb));
    chk("count0", 32'(cnt0), 32'(mq.size()));
    chk("ovf0", 32'(ovf0), 32'(m_ovf));
    chk("busy0", 32'(busy0), 32'(eb));
    chk("txvalid1", 32'(tv1), 32'(ev));
    chk("txbyte1", 32'(tb1), 32'(upc(m_txb)));
    chk("count1", 32'(cnt1), 32'(mq.size()));
    chk("ovf1", 32'(ovf1), 32'(m_ovf));
    chk("busy1", 32'(busy1), 32'(eb));
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check_all();
    if (tv0 && !pv0) begin rises0++; echo0.push_back(tb0); end
    if (tv1 && !pv1) rises1++;
    pv0 = tv0;
    pv1 = tv1;
    if (int'(cnt0) > peak0) peak0 = int'(cnt0);
  endtask

  task automatic wr_byte(input logic [7:0] b);
    rx_byte = b; rx_done = 1'b1; tick();
    rx_done = 1'b0; tick();
  endtask

  task automatic done_pulse();
    tx_done = 1'b1; tick();
    tx_done = 1'b0; tick();
  endtask

  logic [7:0] exp_burst[4] = '{8'hAA, 8'hFF, 8'h00, 8'h12};
  int r_snap;

  initial begin
    // reset
    rst_n = 1'b0;
    tick(); tick();
    chk("rst_count", 32'(cnt0), 32'd0);
    chk("rst_txbyte", 32'(tb0), 32'h00);
    rst_n = 1'b1;
    tick();

    // single byte: request high after k+1 and k+2, low after k+3
    rx_byte = 8'h55; rx_done = 1'b1; tick();
    rx_done = 1'b0; tick();
    chk("single_valid_k1", 32'(tv0), 32'd1);
    chk("single_byte", 32'(tb0), 32'h55);
    tick();
    chk("single_valid_k2", 32'(tv0), 32'd1);
    tick();
    chk("single_valid_k3", 32'(tv0), 32'd0);
    tick();
    tx_done = 1'b1; tick();
    tx_done = 1'b0;
    chk("single_idle_busy", 32'(busy0), 32'd0);
    chk("single_idle_count", 32'(cnt0), 32'd0);
    tick();

    // burst with done held low, then released one handshake at a time
    echo0.delete();
    peak0 = 0;
    foreach (exp_burst[i]) wr_byte(exp_burst[i]);
    chk("burst_peak", 32'(peak0), 32'd3);
    repeat (6) begin done_pulse(); repeat (4) tick(); end
    chk("burst_echo_n", 32'(echo0.size()), 32'd4);
    for (int i = 0; i < 4 && i < echo0.size(); i++) chk("burst_order", 32'(echo0[i]), 32'(exp_burst[i]));

    // overflow: one sent, eight queued, tenth dropped
    for (int i = 1; i <= 10; i++) wr_byte(8'(i));
    chk("ovf_count", 32'(cnt0), 32'd8);
    chk("ovf_flag0", 32'(ovf0), 32'd1);
    chk("ovf_flag1", 32'(ovf1), 32'd1);
    clr = 1'b1; tick();
    clr = 1'b0;
    chk("ovf_cleared", 32'(ovf0), 32'd0);

    // full FIFO: write lands on the same edge as the pop
    tx_done = 1'b1; tick();
    tx_done = 1'b0; rx_byte = 8'h77; rx_done = 1'b1; tick();
    rx_done = 1'b0;
    chk("fullpop_count", 32'(cnt0), 32'd8);
    chk("fullpop_ovf", 32'(ovf0), 32'd0);
    chk("fullpop_byte", 32'(tb0), 32'h02);
    repeat (12) begin done_pulse(); repeat (4) tick(); end
    chk("fullpop_drained", 32'(busy0), 32'd0);

    // level-high done and level-high rx: a single converted echo, parked in WAIT_LOW
    tx_done = 1'b1; rx_byte = 8'h61; rx_done = 1'b1;
    r_snap = rises1;
    repeat (20) tick();
    chk("level_echoes", 32'(rises1 - r_snap), 32'd1);
    chk("level_byte1", 32'(tb1), 32'h41);
    chk("level_byte0", 32'(tb0), 32'h61);
    chk("level_waiting", 32'(busy1), 32'd1);
    rx_done = 1'b0; tx_done = 1'b0; tick();
    tx_done = 1'b1; tick();
    tx_done = 1'b0; tick();
    chk("level_idle", 32'(busy1), 32'd0);

    // reset during SEND with three bytes queued
    for (int i = 0; i < 5; i++) wr_byte(8'h30 + 8'(i));
    tx_done = 1'b1; tick();
    tx_done = 1'b0; tick();
    chk("rstsend_count", 32'(cnt0), 32'd3);
    chk("rstsend_valid", 32'(tv0), 32'd1);
    rx_done = 1'b1; rst_n = 1'b0; tick();
    chk("rstsend_valid_after", 32'(tv0), 32'd0);
    chk("rstsend_count_after", 32'(cnt0), 32'd0);
    chk("rstsend_ovf_after", 32'(ovf0), 32'd0);
    rst_n = 1'b1;
    r_snap = rises0;
    repeat (6) tick();
    chk("rstsend_no_echo", 32'(rises0 - r_snap), 32'd0);
    rx_done = 1'b0; tick();
    wr_byte(8'h3C);
    chk("rstsend_new_echo", 32'(rises0 - r_snap), 32'd1);
    repeat (3) tick();
    done_pulse();

    // randomized traffic
    repeat (600) begin
      rx_done = ($urandom_range(0, 2) == 0);
      rx_byte = $urandom_range(0, 1) ? 8'($urandom_range(8'h5E, 8'h7E)) : 8'($urandom);
      tx_done = ($urandom_range(0, 3) == 0);
      clr     = ($urandom_range(0, 15) == 0);
      rst_n   = ($urandom_range(0, 149) != 0);
      tick();
    end
    rst_n = 1'b1; clr = 1'b0; rx_done = 1'b0; tx_done = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
